dec_4_92_batch32: RTL and testbench

DEC_4_92_BATCH32 -- requirements
Module: dec_4_92_batch32

---
 rtl/dec_pkg.sv | 20 ++
 rtl/dec_mac_lane.sv | 61 ++++++
 rtl/dec_4_92_batch32.sv | 143 ++++++++++++++
 tb/tb_dec_4_92_batch32.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared constants, accumulator sizing and FSM state type for the dec_4_92_batch32 decoder.
package dec_pkg;

  localparam int FRAC_BITS = 11;
  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Full product width plus growth for IN_SIZE terms, one spare bit of headroom.
  function automatic int acc_width(input int bitsize, input int in_size);
    return 2 * bitsize + ((in_size > 1) ? $clog2(in_size) : 0) + 1;
  endfunction

endpackage

// File: rtl/dec_mac_lane.sv
// One output neuron lane: multiply-accumulate, Q4.11 rescale, bias add, saturate.
// Optional ReLU on the saturated result when DEC_RELU_EN is defined.
module dec_mac_lane
  import dec_pkg::*;
#(
  parameter int BITSIZE = 16,
  parameter int IN_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [BITSIZE-1:0] xk,
  input  logic signed [BITSIZE-1:0] wk,
  input  logic signed [BITSIZE-1:0] bias,
  output logic signed [BITSIZE-1:0] res
);

  localparam int ACCW = acc_width(BITSIZE, IN_SIZE);
  localparam int PW   = 2 * BITSIZE;
  localparam logic signed [ACCW-1:0] MAXV = ACCW'(SAT_MAX);
  localparam logic signed [ACCW-1:0] MINV = ACCW'(SAT_MIN);

  logic signed [PW-1:0]      prod;
  logic signed [ACCW-1:0]    acc_q;
  logic signed [ACCW-1:0]    shifted;
  logic signed [ACCW-1:0]    sum;
  logic signed [BITSIZE-1:0] sat_v;

  assign prod = xk * wk;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_q + ACCW'(prod);
    end
  end

  // Arithmetic shift floors toward minus infinity, so -4 >>> 11 gives -1.
  assign shifted = acc_q >>> FRAC_BITS;
  assign sum     = shifted + ACCW'(bias);

  always_comb begin
    sat_v = sum[BITSIZE-1:0];
    if (sum > MAXV) begin
      sat_v = BITSIZE'(SAT_MAX);
    end else if (sum < MINV) begin
      sat_v = BITSIZE'(SAT_MIN);
    end
  end

`ifdef DEC_RELU_EN
  assign res = sat_v[BITSIZE-1] ? '0 : sat_v;
`else
  assign res = sat_v;
`endif

endmodule

// File: rtl/dec_4_92_batch32.sv
// Batched dense decoder: OUT_SIZE neurons from IN_SIZE latents, BATCH lanes per pass.
// Optional build macro DEC_RELU_EN clamps stored outputs at zero.
module dec_4_92_batch32
  import dec_pkg::*;
#(
  parameter int BITSIZE  = 16,
  parameter int IN_SIZE  = 4,
  parameter int OUT_SIZE = 92,
  parameter int BATCH    = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [BITSIZE*IN_SIZE-1:0]           x,
  input  logic [BITSIZE*OUT_SIZE*IN_SIZE-1:0]  w,
  input  logic [BITSIZE*OUT_SIZE-1:0]          b,
  output logic [BITSIZE*OUT_SIZE-1:0]          y,
  output logic                                 busy,
  output logic                                 done_all
);

  localparam int NB = (OUT_SIZE + BATCH - 1) / BATCH;
  localparam int JW = (NB > 1) ? $clog2(NB) : 1;
  localparam int KW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;

  // Handshake: start is a one-cycle request honoured only in IDLE or DONE;
  // x, w and b are read live and must be held stable while busy is high.
  state_t        state_q, state_d;
  logic [JW-1:0] j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic          clr, en, wr;

  logic signed [BITSIZE-1:0] x_k;
  logic signed [BITSIZE-1:0] lane_res [BATCH];
  logic [BITSIZE-1:0]        y_q [OUT_SIZE];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    k_d      = k_q;
    clr      = 1'b0;
    en       = 1'b0;
    wr       = 1'b0;
    busy     = 1'b0;
    done_all = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done_all = (state_q == DONE);
        if (start) begin
          state_d = MAC;
          j_d     = '0;
          k_d     = '0;
          clr     = 1'b1;
        end
      end
      MAC: begin
        busy = 1'b1;
        en   = 1'b1;
        if (k_q == KW'(IN_SIZE - 1)) begin
          state_d = WRITE;
          k_d     = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      WRITE: begin
        busy = 1'b1;
        wr   = 1'b1;
        if (j_q == JW'(NB - 1)) begin
          state_d = DONE;
        end else begin
          state_d = MAC;
          j_d     = j_q + JW'(1);
          clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign x_k = x[int'(k_q)*BITSIZE +: BITSIZE];

  for (genvar l = 0; l < BATCH; l++) begin : g_lane
    logic signed [BITSIZE-1:0] w_cand [2**JW];
    logic signed [BITSIZE-1:0] b_cand [2**JW];

    // Neurons past OUT_SIZE in the last batch see zero operands and are never stored.
    for (genvar jj = 0; jj < 2**JW; jj++) begin : g_cand
      if (jj < NB && jj * BATCH + l < OUT_SIZE) begin : g_live
        assign w_cand[jj] = w[((jj*BATCH + l)*IN_SIZE + int'(k_q))*BITSIZE +: BITSIZE];
        assign b_cand[jj] = b[(jj*BATCH + l)*BITSIZE +: BITSIZE];
      end else begin : g_dead
        assign w_cand[jj] = '0;
        assign b_cand[jj] = '0;
      end
    end

    dec_mac_lane #(
      .BITSIZE (BITSIZE),
      .IN_SIZE (IN_SIZE)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .en    (en),
      .xk    (x_k),
      .wk    (w_cand[j_q]),
      .bias  (b_cand[j_q]),
      .res   (lane_res[l])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < OUT_SIZE; o++) begin
        y_q[o] <= '0;
      end
    end else if (wr) begin
      for (int o = 0; o < OUT_SIZE; o++) begin
        if (j_q == JW'(o / BATCH)) begin
          y_q[o] <= lane_res[o % BATCH];
        end
      end
    end
  end

  for (genvar o = 0; o < OUT_SIZE; o++) begin : g_y
    assign y[o*BITSIZE +: BITSIZE] = y_q[o];
  end

endmodule

// File: tb/tb_dec_4_92_batch32.sv
// Scoreboarded random and directed bench for dec_4_92_batch32 against an arithmetic reference model.
module tb_dec_4_92_batch32;

  localparam int BITSIZE  = 16;
  localparam int IN_SIZE  = 4;
  localparam int OUT_SIZE = 92;
  localparam int BATCH    = 32;
  localparam int XW = BITSIZE * IN_SIZE;
  localparam int WW = BITSIZE * OUT_SIZE * IN_SIZE;
  localparam int YW = BITSIZE * OUT_SIZE;
  localparam int LAT = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [XW-1:0] x;
  logic [WW-1:0] w;
  logic [YW-1:0] b;
  logic [YW-1:0] y;
  logic busy;
  logic done_all;

  always #5 clk = ~clk;

  dec_4_92_batch32 #(
    .BITSIZE  (BITSIZE),
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE),
    .BATCH    (BATCH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .w        (w),
    .b        (b),
    .y        (y),
    .busy     (busy),
    .done_all (done_all)
  );

  int checks = 0;
  int errors = 0;
  logic [YW-1:0] exp_q[$];
  logic [YW-1:0] prev_y;
  logic done_prev = 1'b0;

  // Reference model: y(o) = clamp(floor(sum_k x(k)*w(o,k) / 2048) + b(o)).
  function automatic logic [YW-1:0] model(input logic [XW-1:0] xv, input logic [WW-1:0] wv,
                                          input logic [YW-1:0] bv);
    logic [YW-1:0] r;
    longint s;
    longint v;
    r = '0;
    for (int o = 0; o < OUT_SIZE; o++) begin
      s = 0;
      for (int i = 0; i < IN_SIZE; i++) begin
        s += longint'($signed(xv[i*BITSIZE +: BITSIZE])) *
             longint'($signed(wv[(o*IN_SIZE + i)*BITSIZE +: BITSIZE]));
      end
      v = (s >>> 11) + longint'($signed(bv[o*BITSIZE +: BITSIZE]));
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`ifdef DEC_RELU_EN
      if (v < 0) v = 0;
`endif
      r[o*BITSIZE +: BITSIZE] = v[BITSIZE-1:0];
    end
    return r;
  endfunction

  function automatic int elem(input logic [YW-1:0] v, input int o);
    return int'($signed(v[o*BITSIZE +: BITSIZE]));
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_vec(input string name, input logic [YW-1:0] act, input logic [YW-1:0] req);
    int first;
    checks++;
    if (act !== req) begin
      errors++;
      first = 0;
      for (int o = OUT_SIZE - 1; o >= 0; o--) begin
        if (act[o*BITSIZE +: BITSIZE] !== req[o*BITSIZE +: BITSIZE]) first = o;
      end
      $display("FAIL %s: y(%0d) got %0d, required %0d", name, first, elem(act, first), elem(req, first));
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int xv, input int wv, input int bv);
    for (int i = 0; i < IN_SIZE; i++) x[i*BITSIZE +: BITSIZE] = 16'(xv);
    for (int n = 0; n < OUT_SIZE * IN_SIZE; n++) w[n*BITSIZE +: BITSIZE] = 16'(wv);
    for (int o = 0; o < OUT_SIZE; o++) b[o*BITSIZE +: BITSIZE] = 16'(bv);
  endtask

  task automatic fill_random();
    for (int i = 0; i < IN_SIZE; i++) x[i*BITSIZE +: BITSIZE] = 16'($urandom_range(0, 8192) - 4096);
    for (int n = 0; n < OUT_SIZE * IN_SIZE; n++) w[n*BITSIZE +: BITSIZE] = 16'($urandom);
    for (int o = 0; o < OUT_SIZE; o++) b[o*BITSIZE +: BITSIZE] = 16'($urandom);
  endtask

  // Runs one decode; optional stray start at cycle pulse_at. Result is checked by the monitor.
  task automatic run_decode(input string name, input int pulse_at);
    logic [YW-1:0] e;
    int cyc;
    e = model(x, w, b);
    exp_q.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check({name, "_busy_c1"}, longint'(busy), 1);
    check({name, "_done_c1"}, longint'(done_all), 0);
    check_vec({name, "_y_held_c1"}, y, prev_y);
    while (!done_all && cyc < 40) begin
      if (cyc == pulse_at) start = 1'b1;
      tick();
      start = 1'b0;
      cyc++;
    end
    check({name, "_latency"}, longint'(cyc), LAT);
    check({name, "_busy_done"}, longint'(busy), 0);
    prev_y = e;
  endtask

  // Monitor: pops the expected vector when done_all rises.
  always @(posedge clk) begin
    #2;
    if (done_all && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor_unexpected_done: got done_all=1, required no pending decode");
      end else begin
        check_vec("y_result", y, exp_q.pop_front());
      end
    end
    done_prev = done_all;
  end

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    x = '0;
    w = '0;
    b = '0;
    prev_y = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_vec("reset_y", y, '0);
    check("reset_busy", longint'(busy), 0);
    check("reset_done", longint'(done_all), 0);

    fill(2048, 205, 1024);
    run_decode("unity", 0);
    check("unity_y0", elem(y, 0), 1844);
    check("unity_y91", elem(y, 91), 1844);

    fill(32767, 32767, 32767);
    run_decode("sat_pos", 0);
    check("sat_pos_y50", elem(y, 50), 32767);

    fill(32767, -32768, -32768);
    run_decode("sat_neg", 0);
`ifdef DEC_RELU_EN
    check("sat_neg_y7", elem(y, 7), 0);
`else
    check("sat_neg_y7", elem(y, 7), -32768);
`endif

    fill(2048, -2048, 0);
    run_decode("neg_half", 0);

    fill(1, 1, 0);
    run_decode("tiny_pos", 0);
    check("tiny_pos_y0", elem(y, 0), 0);

    fill(1, -1, 0);
    run_decode("floor_neg", 0);
`ifdef DEC_RELU_EN
    check("floor_neg_y0", elem(y, 0), 0);
`else
    check("floor_neg_y0", elem(y, 0), -1);
`endif

    // Per-neuron identity: w(o,0)=o, other weights random but multiplied by zero latents.
    fill_random();
    x = '0;
    x[0 +: BITSIZE] = 16'd2048;
    b = '0;
    for (int o = 0; o < OUT_SIZE; o++) w[(o*IN_SIZE)*BITSIZE +: BITSIZE] = 16'(o);
    run_decode("ident", 0);
    check("ident_y0", elem(y, 0), 0);
    check("ident_y63", elem(y, 63), 63);
    check("ident_y64", elem(y, 64), 64);
    check("ident_y91", elem(y, 91), 91);

    for (int t = 0; t < 8; t++) begin
      fill_random();
      run_decode("random", 0);
    end

    fill_random();
    run_decode("stray_start", 5);

    // Reset in cycle 7 of a decode aborts it; the pending expectation is dropped.
    fill_random();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (cyc < 7) begin
      tick();
      cyc++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check_vec("midreset_y", y, '0);
    check("midreset_busy", longint'(busy), 0);
    check("midreset_done", longint'(done_all), 0);
    prev_y = '0;
    run_decode("after_reset", 0);

    repeat (4) tick();
    check("queue_drained", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
